// File: rtl/cipu_pkg.sv
// Shared constants, state encodings and helpers for the CIPU host sequencer.
package cipu_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_SEMI   = 8'h3B;
    localparam logic [7:0] CH_NUL    = 8'h00;

    typedef enum logic [1:0] {StIdle, StLaunch, StRun} top_state_e;
    typedef enum logic [2:0] {TStream, TPause, TWlifo, TWfifo2, TFin} thing_state_e;
    typedef enum logic [1:0] {PStream, PWait, PFin} people_state_e;

    function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic en);
        return (en && (v != 6'd63)) ? v + 6'd1 : v;
    endfunction

endpackage

// File: rtl/cipu_char_buf.sv
// Synchronous FIFO with show-ahead read data; clr flushes and overrides push/pop.
module cipu_char_buf #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cipu_seq_ctrl.sv
// Host-side CIPU session sequencer: buffers people/thing streams, launches CIPU,
// paces the characters, counts valid cycles and guards every handshake wait.
module cipu_seq_ctrl
    import cipu_pkg::*;
#(
    parameter int unsigned Depth   = 32,
    parameter int unsigned Timeout = 1023
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       wr_people_i,
    input  logic       wr_thing_i,
    input  logic [7:0] wr_char_i,
    input  logic [3:0] wr_num_i,
    input  logic       start_i,
    output logic       people_full_o,
    output logic       thing_full_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [5:0] cnt_fifo_o,
    output logic [5:0] cnt_lifo_o,
    output logic [5:0] cnt_fifo2_o,
    output logic       ready_fifo_o,
    output logic       ready_lifo_o,
    output logic [7:0] people_thing_in_o,
    output logic [7:0] thing_in_o,
    output logic [3:0] thing_num_o,
    input  logic       valid_fifo_i,
    input  logic       valid_lifo_i,
    input  logic       valid_fifo2_i,
    input  logic       done_thing_i,
    input  logic       done_fifo_i,
    input  logic       done_lifo_i,
    input  logic       done_fifo2_i
);

    localparam int unsigned TmrW = $clog2(Timeout + 1);

    top_state_e    st_q;
    people_state_e p_st_q;
    thing_state_e  t_st_q;
    logic [TmrW-1:0] tmr_q;
    logic [7:0]  people_q, thing_q;
    logic [3:0]  num_q;
    logic [5:0]  cnt_fifo_q, cnt_lifo_q, cnt_fifo2_q;
    logic        ready_q, done_q, err_q;

    logic [7:0]  p_rdata;
    logic [11:0] t_rdata;
    logic        p_empty, t_empty, p_full, t_full;
    logic        idle, start_ok, buf_clr, p_adv, t_adv, waiting, reload, timeout, end_ok;

    assign idle     = (st_q == StIdle);
    assign start_ok = idle && start_i && !p_empty && !clr_i;
    assign end_ok   = (st_q == StRun) && (p_st_q == PFin) && (t_st_q == TFin);
    assign buf_clr  = (idle && clr_i) || end_ok || timeout;

    cipu_char_buf #(.Width(8), .Depth(Depth)) u_people_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (buf_clr),
        .push_i  (wr_people_i && idle),
        .pop_i   (p_adv),
        .wdata_i (wr_char_i),
        .rdata_o (p_rdata),
        .full_o  (p_full),
        .empty_o (p_empty)
    );

    cipu_char_buf #(.Width(12), .Depth(Depth)) u_thing_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (buf_clr),
        .push_i  (wr_thing_i && idle),
        .pop_i   (t_adv),
        .wdata_i ({wr_num_i, wr_char_i}),
        .rdata_o (t_rdata),
        .full_o  (t_full),
        .empty_o (t_empty)
    );

    // p_adv/t_adv: load the next entry (or a synthesized '$') at this edge.
    always_comb begin
        p_adv   = 1'b0;
        t_adv   = 1'b0;
        waiting = 1'b0;
        reload  = 1'b0;
        if (st_q == StLaunch) begin
            p_adv = 1'b1;
            t_adv = 1'b1;
        end else if (st_q == StRun) begin
            p_adv   = (p_st_q == PStream) && (people_q != CH_DOLLAR);
            t_adv   = ((t_st_q == TStream) && (thing_q != CH_SEMI) && (thing_q != CH_DOLLAR)) ||
                      ((t_st_q == TPause) && done_thing_i);
            waiting = (p_st_q == PWait) || (t_st_q inside {TPause, TWlifo, TWfifo2});
            reload  = ((p_st_q == PStream) && (people_q == CH_DOLLAR)) ||
                      ((t_st_q == TStream) && ((thing_q == CH_SEMI) || (thing_q == CH_DOLLAR))) ||
                      ((t_st_q == TWlifo) && done_lifo_i);
        end
    end

    assign timeout = waiting && !reload && (tmr_q == TmrW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q        <= StIdle;
            p_st_q      <= PStream;
            t_st_q      <= TStream;
            tmr_q       <= '0;
            people_q    <= CH_NUL;
            thing_q     <= CH_NUL;
            num_q       <= '0;
            cnt_fifo_q  <= '0;
            cnt_lifo_q  <= '0;
            cnt_fifo2_q <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    if (start_ok) begin
                        st_q        <= StLaunch;
                        ready_q     <= 1'b1;
                        err_q       <= 1'b0;
                        cnt_fifo_q  <= '0;
                        cnt_lifo_q  <= '0;
                        cnt_fifo2_q <= '0;
                    end
                end
                StLaunch: begin
                    st_q   <= StRun;
                    p_st_q <= PStream;
                    t_st_q <= TStream;
                end
                StRun: begin
                    cnt_fifo_q  <= sat_inc(cnt_fifo_q, valid_fifo_i);
                    cnt_lifo_q  <= sat_inc(cnt_lifo_q, valid_lifo_i);
                    cnt_fifo2_q <= sat_inc(cnt_fifo2_q, valid_fifo2_i);
                    if (timeout) begin
                        st_q   <= StIdle;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else if (end_ok) begin
                        st_q   <= StIdle;
                        done_q <= 1'b1;
                    end
                    case (p_st_q)
                        PStream: if (people_q == CH_DOLLAR) p_st_q <= PWait;
                        PWait:   if (done_fifo_i) p_st_q <= PFin;
                        default: ;
                    endcase
                    case (t_st_q)
                        TStream: begin
                            if (thing_q == CH_SEMI)        t_st_q <= TPause;
                            else if (thing_q == CH_DOLLAR) t_st_q <= TWlifo;
                        end
                        TPause:  if (done_thing_i) t_st_q <= TStream;
                        TWlifo:  if (done_lifo_i)  t_st_q <= TWfifo2;
                        TWfifo2: if (done_fifo2_i) t_st_q <= TFin;
                        default: ;
                    endcase
                    if (reload) tmr_q <= TmrW'(Timeout);
                    else if (waiting && (tmr_q != '0)) tmr_q <= tmr_q - 1'b1;
                end
                default: st_q <= StIdle;
            endcase
            // Data lines default to NUL whenever an engine is not presenting an entry.
            if (p_adv && !timeout) people_q <= p_empty ? CH_DOLLAR : p_rdata;
            else                   people_q <= CH_NUL;
            if (t_adv && !timeout) begin
                thing_q <= t_empty ? CH_DOLLAR : t_rdata[7:0];
                num_q   <= t_empty ? 4'd0 : t_rdata[11:8];
            end else begin
                thing_q <= CH_NUL;
                num_q   <= '0;
            end
        end
    end

    assign people_full_o     = p_full;
    assign thing_full_o      = t_full;
    assign busy_o            = !idle;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign cnt_fifo_o        = cnt_fifo_q;
    assign cnt_lifo_o        = cnt_lifo_q;
    assign cnt_fifo2_o       = cnt_fifo2_q;
    assign ready_fifo_o      = ready_q;
    assign ready_lifo_o      = ready_q;
    assign people_thing_in_o = people_q;
    assign thing_in_o        = thing_q;
    assign thing_num_o       = num_q;

endmodule
